// File: rtl/reciprocal_nr_refine.sv
// Newton-Raphson reciprocal refinement behind a 4-bit seed LUT: x <- x*(2 - d*x) in U1.15,
// with one shared 16x16 multiplier, alternating the d*x and x*e products each iteration.
module reciprocal_nr_refine #(
    parameter int ITER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_d,
    output logic [3:0]  lut_idx,
    input  logic [15:0] lut_seed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_recip,
    output logic        out_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SEED, MUL1, MUL2, DONE} state_t;

    localparam logic [2:0] ITER_L = 3'(ITER);

    state_t      state;
    logic [15:0] d_reg;
    logic [15:0] x_reg;
    logic [15:0] t_reg;
    logic [1:0]  iter_cnt;

    logic [16:0] e;
    logic [15:0] e16;
    logic [15:0] mul_a;
    logic [31:0] prod;
    logic [15:0] prod_sat;
    logic [2:0]  iter_next;

    // MUL1 forms d*x; MUL2 reuses the same multiplier for x*(2 - d*x).
    always_comb begin
        e         = 17'h10000 - {1'b0, t_reg};
        e16       = e[16] ? 16'hFFFF : e[15:0];
        mul_a     = (state == MUL1) ? d_reg : e16;
        prod      = 32'(mul_a) * 32'(x_reg);
        prod_sat  = prod[31] ? 16'hFFFF : prod[30:15];
        iter_next = {1'b0, iter_cnt} + 3'd1;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign lut_idx  = d_reg[14:11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_reg     <= '0;
            x_reg     <= '0;
            t_reg     <= '0;
            iter_cnt  <= '0;
            out_valid <= 1'b0;
            out_recip <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= in_d;
                        if (!in_d[15]) begin
                            out_err   <= 1'b1;
                            out_recip <= 16'hFFFF;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_err <= 1'b0;
                            state   <= SEED;
                        end
                    end
                end
                SEED: begin
                    x_reg    <= lut_seed;
                    iter_cnt <= '0;
                    if (ITER_L == 3'd0) begin
                        out_recip <= lut_seed;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    t_reg <= prod_sat;
                    state <= MUL2;
                end
                MUL2: begin
                    x_reg    <= prod_sat;
                    iter_cnt <= iter_cnt + 2'd1;
                    if (iter_next < ITER_L) begin
                        state <= MUL1;
                    end else begin
                        out_recip <= prod_sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result and error flag are held untouched until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reciprocal_nr_refine.sv
// Bench for reciprocal_nr_refine: four instances (ITER=0..3) with a modelled seed LUT,
// directed scenarios on ITER=2 and a randomized sweep of all instances against a reference model.
module tb_reciprocal_nr_refine;
    logic        clk;
    logic        rst_n;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [15:0] in_d      [4];
    logic [3:0]  lut_idx   [4];
    logic [15:0] lut_seed  [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [15:0] out_recip [4];
    logic        out_err   [4];
    logic        busy      [4];

    int checks = 0;
    int errors = 0;

    // Seed table: floor of 1/(1 + idx/16) in U1.15.
    function automatic logic [15:0] seed_of(input logic [3:0] idx);
        return 16'(524288 / (16 + int'(idx)));
    endfunction

    // Newton-Raphson on plain integers, each product truncated to U1.15 and capped at all-ones.
    function automatic logic [15:0] ref_recip(input logic [15:0] d, input int iters);
        longint x, t, e;
        x = longint'(seed_of(d[14:11]));
        for (int i = 0; i < iters; i++) begin
            t = (longint'(d) * x) / 32768;
            if (t > 65535) t = 65535;
            e = 65536 - t;
            if (e > 65535) e = 65535;
            x = (x * e) / 32768;
            if (x > 65535) x = 65535;
        end
        return 16'(x);
    endfunction

    function automatic int ideal_recip(input logic [15:0] d);
        longint dl;
        dl = longint'(d);
        return int'((64'd1073741824 + dl / 2) / dl);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        assign lut_seed[gi] = seed_of(lut_idx[gi]);
        reciprocal_nr_refine #(.ITER(gi)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_d      (in_d[gi]),
            .lut_idx   (lut_idx[gi]),
            .lut_seed  (lut_seed[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_recip (out_recip[gi]),
            .out_err   (out_err[gi]),
            .busy      (busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents d until accepted; returns at the falling edge after the accepting rising edge.
    task automatic send(input int k, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout inst %0d in_ready stayed %b required 1", k, in_ready[k]);
        end
        in_d[k]     = d;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    // lat counts rising edges after the accepting edge until out_valid is seen.
    task automatic get_result(input int k, input int hold, output logic [15:0] r,
                              output logic er, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r  = out_recip[k];
        er = out_err[k];
        repeat (hold) @(negedge clk);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_d[k]      = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || out_recip[k] !== 16'h0 || out_err[k] !== 1'b0 ||
                lut_idx[k] !== 4'h0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst %0d got v%b r%h e%b idx%h rdy%b busy%b required v0 r0000 e0 idx0 rdy1 busy0",
                         k, out_valid[k], out_recip[k], out_err[k], lut_idx[k], in_ready[k], busy[k]);
            end
        end
        $display("reset: outputs checked on all instances");
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] r;
        logic er;
        int lat;
        send(2, 16'hB000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || lut_idx[2] !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_mul1 got v%b rdy%b idx%h required v0 rdy1 idx0",
                     out_valid[2], in_ready[2], lut_idx[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || lut_idx[2] !== 4'h0) begin
            errors++;
            $display("FAIL reset_release got v%b rdy%b idx%h required v0 rdy1 idx0",
                     out_valid[2], in_ready[2], lut_idx[2]);
        end
        send(2, 16'hC000);
        get_result(2, 0, r, er, lat);
        checks++;
        if (er !== 1'b0 || lat != 5 || r < 16'h5554 || r > 16'h5556) begin
            errors++;
            $display("FAIL reset_then_txn got r%h e%b lat%0d required r5555+/-1 e0 lat5", r, er, lat);
        end
        $display("txn reset_mid_op d=c000 r=%h lat=%0d", r, lat);
    endtask

    task automatic test_directed();
        logic [15:0] dv  [4] = '{16'h8000, 16'hC000, 16'h8800, 16'hFFFF};
        logic [3:0]  idx [4] = '{4'd0, 4'd8, 4'd1, 4'd15};
        logic [15:0] lo  [4] = '{16'h8000, 16'h5554, 16'h7877, 16'h3FFF};
        logic [15:0] hi  [4] = '{16'h8000, 16'h5556, 16'h7879, 16'h4001};
        logic [15:0] r;
        logic er;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(2, dv[i]);
            checks++;
            if (lut_idx[2] !== idx[i]) begin
                errors++;
                $display("FAIL directed_idx d=%h got %h required %h", dv[i], lut_idx[2], idx[i]);
            end
            get_result(2, 0, r, er, lat);
            checks++;
            if (er !== 1'b0 || lat != 5 || r < lo[i] || r > hi[i]) begin
                errors++;
                $display("FAIL directed_recip d=%h got r%h e%b lat%0d required r%h..%h e0 lat5",
                         dv[i], r, er, lat, lo[i], hi[i]);
            end
            $display("txn directed d=%h r=%h lat=%0d", dv[i], r, lat);
        end
    endtask

    task automatic test_error();
        logic [15:0] r;
        logic er;
        int lat;
        send(2, 16'h4000);
        get_result(2, 0, r, er, lat);
        checks++;
        if (er !== 1'b1 || r !== 16'hFFFF || lat != 0) begin
            errors++;
            $display("FAIL error_path got r%h e%b lat%0d required rffff e1 lat0", r, er, lat);
        end
        $display("txn error d=4000 r=%h err=%b lat=%0d", r, er, lat);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_r;
        int lat = 0;
        exp_r = ref_recip(16'hA000, 2);
        send(2, 16'hA000);
        while (!out_valid[2] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = c[0];
            in_d[2]     = 16'hF800;
            @(negedge clk);
            checks++;
            if (out_valid[2] !== 1'b1 || out_recip[2] !== exp_r || out_err[2] !== 1'b0 ||
                in_ready[2] !== 1'b0 || lut_idx[2] !== 4'd4) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got v%b r%h e%b rdy%b idx%h required v1 r%h e0 rdy0 idx4",
                         c, out_valid[2], out_recip[2], out_err[2], in_ready[2], lut_idx[2], exp_r);
            end
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || lut_idx[2] !== 4'd4) begin
            errors++;
            $display("FAIL hold_release got v%b rdy%b idx%h required v0 rdy1 idx4",
                     out_valid[2], in_ready[2], lut_idx[2]);
        end
        $display("txn backpressure d=a000 r=%h held 10 cycles", exp_r);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_r;
        logic [15:0] seen_r = '0;
        int n = 0;
        int vat = -1;
        exp_r = ref_recip(16'hE123, 2);
        out_ready[2] = 1'b1;
        send(2, 16'hE123);
        while (!in_ready[2] && n < 100) begin
            if (out_valid[2] && vat < 0) begin
                vat    = n;
                seen_r = out_recip[2];
            end
            @(negedge clk);
            n++;
        end
        out_ready[2] = 1'b0;
        checks++;
        if (n != 6 || vat != 5 || seen_r !== exp_r) begin
            errors++;
            $display("FAIL back_to_back got ready_at %0d valid_at %0d r%h required 6 5 r%h",
                     n, vat, seen_r, exp_r);
        end
        $display("txn back_to_back d=e123 r=%h next accept %0d cycles after accept", seen_r, n + 1);
    endtask

    task automatic sweep_inst(input int k);
        logic [15:0] d, r, exp_r;
        logic er;
        int lat, diff;
        for (int j = 0; j < 512; j++) begin
            d = 16'h8000 | 16'(j << 6) | 16'($urandom_range(0, 63));
            if (j == 0) d = 16'h8000;
            if (j == 511) d = 16'hFFFF;
            exp_r = ref_recip(d, k);
            send(k, d);
            get_result(k, $urandom_range(0, 3), r, er, lat);
            checks++;
            if (r !== exp_r || er !== 1'b0 || lat != 2 * k + 1) begin
                errors++;
                $display("FAIL sweep_model iter %0d d=%h got r%h e%b lat%0d required r%h e0 lat%0d",
                         k, d, r, er, lat, exp_r, 2 * k + 1);
            end
            if (k >= 2) begin
                diff = int'(r) - ideal_recip(d);
                checks++;
                if (diff > 2 || diff < -2) begin
                    errors++;
                    $display("FAIL sweep_accuracy iter %0d d=%h got r%h required %h +/-2",
                             k, d, r, ideal_recip(d));
                end
            end
            $display("txn sweep iter=%0d d=%h r=%h lat=%0d", k, d, r, lat);
        end
    endtask

    task automatic test_sweep();
        fork
            sweep_inst(0);
            sweep_inst(1);
            sweep_inst(2);
            sweep_inst(3);
        join
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_directed();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
